// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt sequencer: opcode encodings, FSM states,
// default vector layout and the instruction-boundary eligibility check.
package irq_pkg;

  localparam logic [6:0]  OP_BRANCH7 = 7'b1100011;
  localparam logic [6:0]  OP_JAL     = 7'b1101111;
  localparam logic [6:0]  OP_JALR    = 7'b1100111;
  localparam logic [11:0] OP_RETIRQ  = 12'b001110011000;

  localparam logic [31:0] DEFAULT_VECTOR_BASE   = 32'h0000_0100;
  localparam int          DEFAULT_VECTOR_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Control transfers and RETIRQ are excluded so the return address is always pc+4.
  function automatic logic is_eligible(input logic [11:0] op);
    logic elig;
    case (op[6:0])
      OP_BRANCH7, OP_JAL, OP_JALR: elig = 1'b0;
      default:                     elig = (op != OP_RETIRQ);
    endcase
    return elig;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-bit two-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] delayed;

  // Synchroniser chain plus the history flop used for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= {WIDTH{1'b0}};
      sync2   <= {WIDTH{1'b0}};
      delayed <= {WIDTH{1'b0}};
    end else begin
      sync1   <= async_in;
      sync2   <= sync1;
      delayed <= sync2;
    end
  end

  assign rise = sync2 & ~delayed;

endmodule

// File: rtl/irq_sequencer.sv
// Latches edge-triggered interrupt requests, picks the lowest-index enabled one and
// redirects the PC at an eligible retire, holding the return PC until RETIRQ.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int          N_IRQ         = 8,
  parameter logic [31:0] VECTOR_BASE   = DEFAULT_VECTOR_BASE,
  parameter int          VECTOR_STRIDE = DEFAULT_VECTOR_STRIDE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic [31:0]      pc,
  input  logic [11:0]      opcode,
  input  logic             enable_pc,
  output logic             irr,
  output logic [31:0]      irr_dest,
  output logic [31:0]      irr_ret,
  output logic             in_service,
  output logic [3:0]       active_id,
  output logic [N_IRQ-1:0] pending
);

  localparam logic [N_IRQ-1:0] ONE_HOT0 = N_IRQ'(1);

  irq_state_e       state;
  irq_state_e       next_state;
  logic [3:0]       next_id;
  logic [3:0]       winner;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] clr;
  logic             take;
  logic             irr_c;

  irq_sync_edge #(.WIDTH(N_IRQ)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (irq_in),
    .rise     (rise)
  );

  assign cand = pending & mask;

  // Fixed priority: scanning downward leaves the lowest set index as the winner.
  always_comb begin
    winner = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      winner = cand[i] ? 4'(i) : winner;
    end
  end

  // Next-state logic; in ARMED the selection tracks the winner until entry.
  always_comb begin
    next_state = state;
    next_id    = active_id;
    take       = 1'b0;
    irr_c      = 1'b0;
    case (state)
      IDLE: begin
        if (cand != {N_IRQ{1'b0}}) begin
          next_state = ARMED;
          next_id    = winner;
        end else begin
          next_state = IDLE;
        end
      end
      ARMED: begin
        irr_c = is_eligible(opcode);
        if (enable_pc && irr_c) begin
          take       = 1'b1;
          next_state = SERVICE;
        end else if (cand == {N_IRQ{1'b0}}) begin
          next_state = IDLE;
        end else begin
          next_id = winner;
        end
      end
      SERVICE: begin
        if (enable_pc && (opcode == OP_RETIRQ)) begin
          next_state = IDLE;
        end else begin
          next_state = SERVICE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign clr = take ? (ONE_HOT0 << active_id) : {N_IRQ{1'b0}};

  // State, selection, mask, return PC and pending latch; a new edge beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      active_id <= 4'd0;
      mask      <= {N_IRQ{1'b0}};
      pending   <= {N_IRQ{1'b0}};
      irr_ret   <= 32'd0;
    end else begin
      state     <= next_state;
      active_id <= next_id;
      mask      <= mask_we ? mask_wdata : mask;
      pending   <= (pending & ~clr) | rise;
      irr_ret   <= take ? (pc + 32'd4) : irr_ret;
    end
  end

  assign irr        = irr_c;
  assign irr_dest   = VECTOR_BASE + (32'(active_id) * 32'(VECTOR_STRIDE));
  assign in_service = (state == SERVICE);

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
Interrupt controller that owns the `irr`/`irr_dest`/`irr_ret` inputs of the PC/CSR utility datapath. It synchronises and latches up to N_IRQ edge-triggered requests, arbitrates them by fixed priority, and redirects the program counter at a safe instruction boundary. It holds the return address until RETIRQ retires. It sits beside the PC/utility unit and sequences every PC redirect that is not program-driven.

Parameters:
N_IRQ, 8, number of interrupt sources (1..16).
VECTOR_BASE, 32'h0000_0100, address of the vector for source 0.
VECTOR_STRIDE, 4, byte distance between consecutive vectors.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
irq_in  input  N_IRQ  raw asynchronous requests; rising edge = request.
mask_we  input  1  write strobe for the mask register.
mask_wdata  input  N_IRQ  new mask value; 1 = enabled.
pc  input  32  current PC (registered PC of the utility unit).
opcode  input  12  decoded opcode of the instruction in flight.
enable_pc  input  1  instruction retire strobe; PC updates this cycle.
irr  output  1  redirect request to the PC unit.
irr_dest  output  32  redirect target.
irr_ret  output  32  saved return PC; the target used on RETIRQ.
in_service  output  1  a handler is active.
active_id  output  4  id of the source pending or in service.
pending  output  N_IRQ  latched, not yet taken requests; unmasked view.

Behaviour:
- Reset: asynchronous, active-low. While `rst`=0 all flops clear immediately: synchronisers, pending=0, mask=0, state=IDLE, irr_ret=0, active_id=0. Outputs: irr=0, irr_dest=VECTOR_BASE, in_service=0. Reset mid-handler discards the saved return PC.
- Input path: 2-flop synchroniser per bit, then rising-edge detect (3rd flop). An edge sets `pending[i]` 3 cycles after the `irq_in` rise.
- Mask: `mask_we` loads the mask next edge. Masking never clears `pending`; it only hides the bit from arbitration.
- Candidates: `cand = pending & mask`. Winner = lowest set index; index 0 has the highest priority.
- Eligibility: the current instruction is eligible when `opcode[6:0]` is not 1100011 (branch), 1101111 (JAL) or 1100111 (JALR), and `opcode` is not 12'b001110011000 (RETIRQ). With control transfers excluded, the return address is always `pc`+4.
- State machine:
  - IDLE: in_service=0. If cand≠0 → ARMED next cycle, active_id<=winner.
  - ARMED: active_id re-evaluates to the winner each cycle, so a higher priority arriving late preempts the selection. If cand becomes 0 (masked away) → IDLE. `irr` = ARMED && eligible(opcode), combinational; `irr_dest` = VECTOR_BASE + active_id*VECTOR_STRIDE, 32-bit modulo. On `enable_pc && irr`: irr_ret<=pc+4 (modulo 2^32), pending[active_id] cleared, → SERVICE.
  - SERVICE: in_service=1, irr=0, no nesting; pending keeps accumulating. On `enable_pc` with opcode=RETIRQ → IDLE. The PC unit uses `irr_ret`, which stays stable through that cycle.
- Simultaneous set and clear of the same pending bit: set wins, so the request is re-taken later.
- Back-to-back interrupts: after RETIRQ, IDLE→ARMED costs one cycle, so a pending request is taken on the first eligible retire at least 2 cycles later.
- `irr` is never asserted outside ARMED. `irr_ret` changes only on interrupt entry.

Decomposition:
- Shared package `irq_pkg`:
  - opcode constants: OP_BRANCH7, OP_JAL, OP_JALR, OP_RETIRQ;
  - state enum (IDLE, ARMED, SERVICE);
  - the default VECTOR_BASE / VECTOR_STRIDE.
- One sub-module, `irq_sync_edge`: per-bit 2-flop synchroniser plus edge detector, parameterised by width, async active-low reset.
- Priority encoder stays inline.

Test Plan:
- Basic take: mask=8'hFF, pulse irq_in[3], pc=0x40, ADDI retiring → irr=1, irr_dest=0x10C, and the retire with irr=1 loads irr_ret=0x44. Then in_service=1, pending[3]=0.
- Priority/preempt: irq[5] goes ARMED, then irq[1] arrives before any eligible retire → active_id switches to 1, irr_dest=0x104. After entry, irq[5] stays pending.
- Deferral: ARMED while opcode=JAL (12'b000001101111) for 3 retires → irr=0 throughout. The first ADDI retire at pc=0x80 takes it with irr_ret=0x84.
- RETIRQ and nesting: in SERVICE, pulse irq[0] → irr stays 0. RETIRQ retire → IDLE, then ARMED 1 cycle later with active_id=0.
- Masking: pending[2]=1 with mask[2]=0 → stays IDLE, pending[2] remains 1. Write mask=8'h04 → ARMED, irr_dest=0x108.
- Async reset: assert rst=0 mid-SERVICE between clock edges → in_service, irr, pending, irr_ret are 0 immediately. After release with no edges, the block stays IDLE.
